// File: rtl/game_fsm.sv
// game_fsm: dino-runner game state controller.
// Drives the 2-bit state bus (IDLE/RUN/FAST/GAMEOVER), a 4-digit BCD score that
// advances once every SCORE_DIV frames while running, promotion to FAST at a
// score threshold, game-over latching on collision and a frame-counted restart
// hold-off.
// Optional feature: define HI_SCORE_EN to keep a best-score register (hi_score);
// without it hi_score is tied to zero and no compare or register is built.
module game_fsm #(
   parameter int unsigned SCORE_DIV     = 6,
   parameter logic [15:0] FAST_SCORE    = 16'h0300,
   parameter int unsigned GAMEOVER_HOLD = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_frame,
   input  logic        btn_jump,
   input  logic        collision,
   output logic [1:0]  state,
   output logic [15:0] score,
   output logic [15:0] hi_score,
   output logic        run_start
);

   localparam int unsigned DIV_W   = 6;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned SCORE_W = 16;

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(GAMEOVER_HOLD);
   localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

   // 00/11 freeze the ground, 01/10 scroll it; the ground block relies on this.
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FAST = 2'b10,
      S_OVER = 2'b11
   } state_t;

   state_t               state_q;
   logic [DIV_W-1:0]     frame_div;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [SCORE_W-1:0]   score_inc_c;

   // Per-digit BCD increment with ripple carry; each digit wraps 9 -> 0.
   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      logic               carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Next score value, saturating at 9999.
   always_comb begin
      score_inc_c = score;
      if (score != SCORE_MAX) begin
         score_inc_c = bcd_inc(score);
      end
   end

   // Game state machine with registered score, divider, hold-off and run_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         score     <= '0;
         frame_div <= '0;
         hold_cnt  <= '0;
         run_start <= 1'b0;
      end else begin
         run_start <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (btn_jump) begin
                  state_q   <= S_RUN;
                  score     <= '0;
                  frame_div <= '0;
                  run_start <= 1'b1;
               end
            end
            S_RUN, S_FAST: begin
               if (collision) begin
                  // Score freezes; any same-cycle increment is dropped.
                  state_q  <= S_OVER;
                  hold_cnt <= HOLD_INIT;
               end else begin
                  if (new_frame) begin
                     if (frame_div == DIV_LAST) begin
                        frame_div <= '0;
                        score     <= score_inc_c;
                     end else begin
                        frame_div <= frame_div + DIV_W'(1);
                     end
                  end
                  // Promotion looks at the registered score, so it lands one clock later.
                  if (state_q == S_RUN && score >= FAST_SCORE) begin
                     state_q <= S_FAST;
                  end
               end
            end
            S_OVER: begin
               if (new_frame && hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
               // Press is judged on the pre-decrement hold count.
               if (btn_jump && hold_cnt == '0) begin
                  state_q   <= S_RUN;
                  score     <= '0;
                  frame_div <= '0;
                  run_start <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign state = state_q;

`ifdef HI_SCORE_EN
   // Best score: score is frozen in GAMEOVER, so the compare settles one clock after entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_score <= '0;
      end else if (state_q == S_OVER && score > hi_score) begin
         hi_score <= score;
      end
   end
`else
   assign hi_score = '0;
`endif

endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed + randomized bench for game_fsm with a behavioural model.
module tb_game_fsm;

   localparam int unsigned DIV  = 3;
   localparam int unsigned HOLD = 30;
   localparam int          FAST_PTS = 300;   // 16'h0300 as a plain number

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        new_frame = 1'b0;
   logic        btn_jump = 1'b0;
   logic        collision = 1'b0;
   logic [1:0]  state;
   logic [15:0] score;
   logic [15:0] hi_score;
   logic        run_start;

   int n_cmp = 0;
   int n_bad = 0;

   game_fsm #(
      .SCORE_DIV    (DIV),
      .FAST_SCORE   (16'h0300),
      .GAMEOVER_HOLD(HOLD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .new_frame(new_frame),
      .btn_jump (btn_jump),
      .collision(collision),
      .state    (state),
      .score    (score),
      .hi_score (hi_score),
      .run_start(run_start)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Game phase kept as plain names; the state code is a lookup.
   localparam int P_IDLE = 0, P_RUN = 1, P_FAST = 2, P_OVER = 3;
   int m_phase = P_IDLE;
   int m_points = 0;      // score as an ordinary integer
   int m_frames = 0;      // frames seen since last point
   int m_wait = 0;        // frames still to wait before restart allowed
   int m_best = 0;
   bit m_started = 1'b0;

   function automatic logic [15:0] to_bcd(input int n);
      logic [3:0] d3, d2, d1, d0;
      d3 = 4'((n / 1000) % 10);
      d2 = 4'((n / 100) % 10);
      d1 = 4'((n / 10) % 10);
      d0 = 4'(n % 10);
      return {d3, d2, d1, d0};
   endfunction

   function automatic logic [1:0] phase_code(input int p);
      logic [1:0] tbl [4];
      tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b10; tbl[3] = 2'b11;
      return tbl[p];
   endfunction

   always @(posedge clk) begin
      bit may_go;
      if (rst) begin
         m_phase = P_IDLE; m_points = 0; m_frames = 0; m_wait = 0;
         m_best = 0; m_started = 1'b0;
      end else begin
`ifdef HI_SCORE_EN
         if (m_phase == P_OVER && m_points > m_best) m_best = m_points;
`endif
         m_started = 1'b0;
         if (m_phase == P_IDLE) begin
            if (btn_jump) begin
               m_phase = P_RUN; m_points = 0; m_frames = 0; m_started = 1'b1;
            end
         end else if (m_phase == P_OVER) begin
            may_go = btn_jump && (m_wait == 0);
            if (new_frame && m_wait > 0) m_wait = m_wait - 1;
            if (may_go) begin
               m_phase = P_RUN; m_points = 0; m_frames = 0; m_started = 1'b1;
            end
         end else if (collision) begin
            m_phase = P_OVER; m_wait = HOLD;
         end else begin
            if (m_phase == P_RUN && m_points >= FAST_PTS) m_phase = P_FAST;
            if (new_frame) begin
               m_frames = m_frames + 1;
               if (m_frames == DIV) begin
                  m_frames = 0;
                  if (m_points < 9999) m_points = m_points + 1;
               end
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clk) begin
      n_cmp = n_cmp + 1;
      if (state !== phase_code(m_phase) || score !== to_bcd(m_points) ||
          hi_score !== to_bcd(m_best) || run_start !== m_started) begin
         n_bad = n_bad + 1;
         $display("FAIL model t=%0t: got state=%b score=%h hi=%h rs=%b required state=%b score=%h hi=%h rs=%b",
                  $time, state, score, hi_score, run_start,
                  phase_code(m_phase), to_bcd(m_points), to_bcd(m_best), m_started);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit j, input bit f, input bit c, input bit r);
      btn_jump = j; new_frame = f; collision = c; rst = r;
      @(negedge clk);
      #1;
      btn_jump = 1'b0; new_frame = 1'b0; collision = 1'b0; rst = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

`ifdef HI_SCORE_EN
   localparam logic [15:0] HI_EXP = 16'h0042;
`else
   localparam logic [15:0] HI_EXP = 16'h0000;
`endif

   initial begin
      // Reset state
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      lit("reset_state", 16'(state), 16'h0000);
      lit("reset_score", score, 16'h0000);
      lit("reset_hi", hi_score, 16'h0000);
      lit("reset_rs", 16'(run_start), 16'h0000);

      // Start with coincident frame: no score update that cycle
      step(1'b1, 1'b1, 1'b0, 1'b0);
      lit("start_state", 16'(state), 16'h0001);
      lit("start_rs", 16'(run_start), 16'h0001);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      lit("rs_one_cycle", 16'(run_start), 16'h0000);

      // Scoring and BCD carries
      frames(30);
      lit("score_10", score, 16'h0010);
      frames(89 * DIV);
      lit("score_99", score, 16'h0099);
      frames(DIV);
      lit("score_100", score, 16'h0100);

      // Promotion one clock after reaching 0300
      frames(200 * DIV);
      lit("score_300", score, 16'h0300);
      lit("pre_promo_state", 16'(state), 16'h0001);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      lit("promo_state", 16'(state), 16'h0002);

      // Collision on a score-step cycle: increment dropped
      frames(DIV - 1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      lit("coll_state", 16'(state), 16'h0003);
      lit("coll_score", score, 16'h0300);

      // Hold-off
      frames(HOLD - 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      lit("hold_29_jump", 16'(state), 16'h0003);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      lit("hold_jump_with_last_frame", 16'(state), 16'h0003);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      lit("restart_state", 16'(state), 16'h0001);
      lit("restart_score", score, 16'h0000);
      lit("restart_rs", 16'(run_start), 16'h0001);

      // Reset held mid-FAST
      frames(300 * DIV);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      lit("fast_again", 16'(state), 16'h0002);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      lit("t1_state", 16'(state), 16'h0000);
      lit("t1_score", score, 16'h0000);
      lit("t1_hi", hi_score, 16'h0000);
      lit("t1_rs", 16'(run_start), 16'h0000);

      // Best score across two games
      step(1'b1, 1'b0, 1'b0, 1'b0);
      frames(42 * DIV);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      lit("game1_score", score, 16'h0042);
      frames(HOLD);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      frames(17 * DIV);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      lit("game2_score", score, 16'h0017);
      lit("hi_after_two", hi_score, HI_EXP);

      // Saturation at 9999
      frames(HOLD);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      frames(9999 * DIV);
      lit("sat_reach", score, 16'h9999);
      frames(2 * DIV);
      lit("sat_hold", score, 16'h9999);
      lit("sat_state", 16'(state), 16'h0002);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
